// File: rtl/hwag_angle_counter.sv
// Crank angle counter: turns tooth/sync pulses into {tooth_index, sub_step},
// interpolating each tooth with sub-steps timed from the previous tooth period.
module hwag_angle_counter #(
    parameter int TEETH        = 120,
    parameter int STEP_SHIFT   = 6,
    parameter int PERIOD_WIDTH = 24,
    parameter int ANGLE_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    ena,
    input  logic                    tooth,
    input  logic                    sync,
    output logic [ANGLE_WIDTH-1:0]  angle_out,
    output logic                    angle_valid,
    output logic                    step,
    output logic [PERIOD_WIDTH-1:0] tooth_period,
    output logic                    stall,
    output logic                    sync_error
);

    localparam int IDX_W = (TEETH > 1) ? $clog2(TEETH) : 1;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(TEETH - 1);
    localparam logic [IDX_W-1:0]        ONE_I    = IDX_W'(1);
    localparam logic [PERIOD_WIDTH-1:0] ONE_P    = PERIOD_WIDTH'(1);
    localparam logic [STEP_SHIFT-1:0]   ONE_S    = STEP_SHIFT'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t                  r_state;
    logic [PERIOD_WIDTH-1:0] r_period_cnt;
    logic [PERIOD_WIDTH-1:0] r_tooth_period;
    logic [PERIOD_WIDTH-1:0] r_step_timer;
    logic [IDX_W-1:0]        r_tooth_index;
    logic [STEP_SHIFT-1:0]   r_sub_step;
    logic                    r_angle_valid;
    logic                    r_step;
    logic                    r_stall;
    logic                    r_sync_error;

    logic                    w_period_max;
    logic [PERIOD_WIDTH-1:0] w_captured;
    logic [PERIOD_WIDTH-1:0] w_interval_raw;
    logic [PERIOD_WIDTH-1:0] w_step_interval;
    logic                    w_sub_full;
    logic                    w_step_due;
    logic [IDX_W-1:0]        w_next_index;

    assign w_period_max    = (r_period_cnt == {PERIOD_WIDTH{1'b1}});
    assign w_captured      = r_period_cnt + ONE_P;
    assign w_interval_raw  = r_tooth_period >> STEP_SHIFT;
    // Very short teeth still need a non-zero interval so sub-steps keep advancing.
    assign w_step_interval = (w_interval_raw == {PERIOD_WIDTH{1'b0}}) ? ONE_P : w_interval_raw;
    assign w_sub_full      = (r_sub_step == {STEP_SHIFT{1'b1}});
    assign w_step_due      = ((r_step_timer + ONE_P) == w_step_interval) && !w_sub_full;
    assign w_next_index    = (r_tooth_index == LAST_IDX) ? {IDX_W{1'b0}} : (r_tooth_index + ONE_I);

    assign angle_out    = ANGLE_WIDTH'({r_tooth_index, r_sub_step});
    assign angle_valid  = r_angle_valid;
    assign step         = r_step;
    assign tooth_period = r_tooth_period;
    assign stall        = r_stall;
    assign sync_error   = r_sync_error;

    // Mode sequencing, period measurement, angle position and output pulses
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state        <= S_IDLE;
            r_period_cnt   <= {PERIOD_WIDTH{1'b0}};
            r_tooth_period <= {PERIOD_WIDTH{1'b0}};
            r_step_timer   <= {PERIOD_WIDTH{1'b0}};
            r_tooth_index  <= {IDX_W{1'b0}};
            r_sub_step     <= {STEP_SHIFT{1'b0}};
            r_angle_valid  <= 1'b0;
            r_step         <= 1'b0;
            r_stall        <= 1'b0;
            r_sync_error   <= 1'b0;
        end else if (ena) begin
            r_step       <= 1'b0;
            r_stall      <= 1'b0;
            r_sync_error <= 1'b0;

            if (tooth || sync) begin
                r_period_cnt <= {PERIOD_WIDTH{1'b0}};
            end else if (!w_period_max) begin
                r_period_cnt <= r_period_cnt + ONE_P;
            end

            // A saturated period means the wheel stopped: drop lock before anything else.
            if ((r_state != S_IDLE) && w_period_max) begin
                r_state       <= S_IDLE;
                r_angle_valid <= 1'b0;
                r_tooth_index <= {IDX_W{1'b0}};
                r_sub_step    <= {STEP_SHIFT{1'b0}};
                r_step_timer  <= {PERIOD_WIDTH{1'b0}};
                r_stall       <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (sync) begin
                            r_state       <= S_MEASURE;
                            r_tooth_index <= {IDX_W{1'b0}};
                            r_sub_step    <= {STEP_SHIFT{1'b0}};
                        end
                    end
                    S_MEASURE: begin
                        if (sync) begin
                            r_tooth_index <= {IDX_W{1'b0}};
                            r_sub_step    <= {STEP_SHIFT{1'b0}};
                        end else if (tooth) begin
                            r_state        <= S_RUN;
                            r_angle_valid  <= 1'b1;
                            r_tooth_period <= w_captured;
                            r_tooth_index  <= ONE_I;
                            r_sub_step     <= {STEP_SHIFT{1'b0}};
                            r_step_timer   <= {PERIOD_WIDTH{1'b0}};
                            r_step         <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (sync) begin
                            r_tooth_period <= w_captured;
                            r_sync_error   <= (r_tooth_index != LAST_IDX);
                            r_tooth_index  <= {IDX_W{1'b0}};
                            r_sub_step     <= {STEP_SHIFT{1'b0}};
                            r_step_timer   <= {PERIOD_WIDTH{1'b0}};
                            r_step         <= 1'b1;
                        end else if (tooth) begin
                            r_tooth_period <= w_captured;
                            r_tooth_index  <= w_next_index;
                            r_sub_step     <= {STEP_SHIFT{1'b0}};
                            r_step_timer   <= {PERIOD_WIDTH{1'b0}};
                            r_step         <= 1'b1;
                        end else if (w_step_due) begin
                            r_sub_step   <= r_sub_step + ONE_S;
                            r_step_timer <= {PERIOD_WIDTH{1'b0}};
                            r_step       <= 1'b1;
                        end else begin
                            r_step_timer <= r_step_timer + ONE_P;
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_angle_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/hwag_angle_counter.md
Name: hwag_angle_counter

Overview:
- Upstream angle source for the set/reset output comparators: turns the conditioned crank tooth pulse stream into a fine-grained engine-cycle angle.
- Each tooth period is split into 2^STEP_SHIFT sub-steps, using the previous tooth period as the time base.
- angle_out drives the comparators' compare-data input.
- A sync pulse (the reference tooth, after gap detection) anchors the angle at 0.

Parameters:
- TEETH, 120, tooth positions per engine cycle; tooth_index range is 0..TEETH-1.
- STEP_SHIFT, 6, log2 of sub-steps per tooth.
- PERIOD_WIDTH, 24, width of the tooth period counter and capture register.
- ANGLE_WIDTH, 24, width of angle_out; must be at least clog2(TEETH)+STEP_SHIFT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- arst  in  1  asynchronous active-high reset.
- ena  in  1  clock enable; low freezes all state and ignores tooth/sync.
- tooth  in  1  single-cycle pulse per non-reference tooth, already synchronised.
- sync  in  1  single-cycle pulse on the reference tooth (tooth 0); never coincident with tooth.
- angle_out  out  ANGLE_WIDTH  {tooth_index, sub_step}, zero-extended.
- angle_valid  out  1  high while state is RUN.
- step  out  1  one-cycle pulse whenever angle_out changes in RUN.
- tooth_period  out  PERIOD_WIDTH  last captured tooth period in ena cycles.
- stall  out  1  one-cycle pulse when the period counter saturates.
- sync_error  out  1  one-cycle pulse when sync arrives with tooth_index != TEETH-1 in RUN.

Behaviour:
- Reset values (arst async): all registers and outputs 0, state IDLE. Applies mid-operation as well.
- All outputs are registered; each responds in the cycle after the causing input is sampled.
- With ena low, nothing changes and tooth/sync are not latched.
- Period counter:
  - Increments every ena cycle and clears to 0 on tooth or sync.
  - The captured period is period_cnt+1, i.e. ena cycles between pulses.
  - Reaching all-ones in MEASURE or RUN forces IDLE, pulses stall and zeroes angle_out.
- step_interval = tooth_period >> STEP_SHIFT, forced to 1 if the result is 0.
- step_timer increments each ena cycle in RUN. When step_timer+1 == step_interval and sub_step < 2^STEP_SHIFT-1:
  - sub_step increments, step pulses, step_timer clears.
- sub_step saturates at 2^STEP_SHIFT-1; after that, no further step until the next tooth or sync.
- State IDLE:
  - tooth ignored.
  - sync -> MEASURE, tooth_index=0, sub_step=0, period counter cleared.
- State MEASURE:
  - tooth -> RUN; capture tooth_period; tooth_index=1; sub_step=0; step pulses.
  - sync -> stay in MEASURE, restart the measurement.
- State RUN, on tooth:
  - Capture tooth_period.
  - tooth_index = (tooth_index==TEETH-1) ? 0 : tooth_index+1.
  - sub_step=0, step_timer=0, step pulses.
- State RUN, on sync:
  - Capture tooth_period; tooth_index=0; sub_step=0; step_timer=0; step pulses.
  - sync_error pulses if the pre-sync tooth_index != TEETH-1. The position is resynchronised regardless.
- A tooth or sync edge takes priority over a sub-step in the same cycle; the sub-step is discarded.
- The new tooth_period takes effect for step_interval from the cycle after capture.

Test Plan:
All runs use TEETH=4, STEP_SHIFT=2, PERIOD_WIDTH=8.
- arst pulse mid-RUN -> all outputs 0 and state IDLE immediately. tooth pulses before the next sync -> angle_valid stays 0, step never pulses.
- sync at t0, tooth at t0+16:
  - Next cycle: angle_valid=1, tooth_period=16, angle_out=4, step=1.
  - Then step at +4/+8/+12 cycles, angle_out=5,6,7.
  - Next tooth at +16 -> angle_out=8.
- Continuing 16-cycle pulses through the tooth_index=3 sync -> angle_out 12..15 then 0, sync_error=0. Sync injected at tooth_index=2 -> sync_error=1, angle_out=0.
- Tooth spacing drops to 8 -> tooth_period=8, interval 2, sub-steps every 2 cycles. Spacing rises to 40 with last period 16 -> sub_step stops at 3 (angle_out=xx11b) for ~28 cycles, no extra step.
- No tooth for 256 cycles in RUN -> stall pulses once, angle_valid=0, angle_out=0; a later tooth without sync is ignored.
- ena held low 10 cycles mid-step with a tooth pulse inside the window -> angle_out, step_timer and tooth_period unchanged, tooth not counted; resumes on the exact next cycle when ena returns.
